bk_sync_ctrl: RTL and testbench
===============================

# bk_sync_ctrl

Sequences backup-RAM (BSRAM) transfers between the on-chip BSRAM and the mounted save file on SD, one 512-byte sector per hps_io sector handshake. It tracks which sectors the core has written since the last sync, so autosave writes back only dirty sectors. Manual load/save and load-after-ROM-download are handled by the same engine. It sits between hps_io's sd_* handshake, the OSD status bits, and the BSRAM write strobe from the core.

## Interface
Parameters:
- SEC_W, 8: sector index width; max 256 sectors = 128 KB.
- TIMEOUT, 2000000: clk_sys cycles allowed from request to sd_ack rise.

Ports (reset is synchronous, active-low; clock is clk_sys):
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-low
- bk_ena  in  1  writable save file mounted; when low, all requests ignored
- ram_mask  in  24  BSRAM byte mask; last sector = ram_mask[SEC_W+8:9]
- load_req  in  1  OSD load level; rising edge triggers
- save_req  in  1  OSD save level; rising edge triggers full save
- auto_tick  in  1  one-cycle pulse; triggers dirty-only save
- dl_done  in  1  one-cycle pulse at end of ROM download
- bsram_we  in  1  core BSRAM write strobe
- bsram_addr  in  17  core BSRAM write address
- sd_lba  out  32  sector number; upper bits 0
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  hps_io acknowledge
- bk_loading  out  1  high during a load; holds core in reset
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag; cleared by the next accepted request

## Operation
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, bk_loading=0, busy=0, err=0. Dirty map is cleared; edge detectors are loaded with current input levels so held levels do not fire.
- Dirty map: bit[bsram_addr[16:9]] is set on bsram_we. A set and a clear of the same bit in the same cycle resolves to set.
- States: IDLE, SCAN, REQ, XFER.
- IDLE:
  - Accepts one trigger per cycle. Priority: dl_done > load edge > save edge > auto_tick.
  - Triggers are ignored while busy.
  - dl_done arriving while busy is latched as pending and serviced on return to IDLE.
- Trigger effects:
  - Load and dl_done: mode=READ, idx=0, go to REQ.
  - Save: mode=WRITE, all=1, idx=0, go to SCAN.
  - Auto: mode=WRITE, all=0, idx=0, go to SCAN.
- SCAN:
  - Examines one index per cycle.
  - If all=1 or dirty[idx]=1, go to REQ.
  - Otherwise, if idx==last, go to IDLE; else idx+1.
- REQ:
  - sd_lba=idx; sd_rd=(mode==READ); sd_wr=(mode==WRITE).
  - For a write, clear dirty[idx] in this cycle.
  - Start timeout counter, go to XFER.
- XFER:
  - On sd_ack rise: drop sd_rd/sd_wr.
  - On sd_ack fall: sector done. If idx==last, finish to IDLE. Otherwise idx+1, then SCAN (write) or REQ (read).
- Finish after a READ: clear the whole dirty map, drop bk_loading.
- Timeout: counter reaches TIMEOUT before sd_ack rise. Drop sd_rd/sd_wr, set err, set bk_loading=0, go to IDLE. For a write, re-set dirty[idx].
- bk_ena falling mid-operation: finish the current sector handshake, then go to IDLE.
- Reset mid-operation: sd_rd/sd_wr drop in the next cycle; no partial state is retained.

## Timing
- Trigger sampled in cycle N, so REQ in N+1 for a read. For a write, SCAN starts in N+1, so REQ occurs no earlier than N+2.
- sd_rd/sd_wr are registered: high from the cycle after REQ until the cycle after the sd_ack rise.
- Sector-to-sector gap after sd_ack fall: 1 cycle (read), 2 or more cycles (write, including scan).
- Worst-case scan: 2^SEC_W cycles.
- bk_loading is high from the cycle after the load trigger through the cycle after the final sd_ack fall.
- Timeout counter is 22 bits wide and saturates.

## Structure
- Package bk_sync_pkg holds:
  - state enum (IDLE, SCAN, REQ, XFER)
  - mode enum (READ, WRITE)
  - SECTOR_BYTES=512
- Sub-module dirty_map holds the 2^SEC_W-bit register. Ports: set_en/set_idx, clr_en/clr_idx, clr_all, rd_idx, rd_bit. It enforces set-wins-over-clear priority.

## Test plan
- ram_mask=24'h1FFF (16 sectors), dl_done pulse, ack every request:
  - exactly 16 sd_rd requests, lba 0..15
  - bk_loading high throughout, low after lba 15 ack falls
- Core writes to addrs 0x0200 and 0x1E00, then auto_tick:
  - sd_wr only for lba 1 and lba 15
  - dirty map empty afterwards
- save_req rising edge with clean map, ram_mask=24'h7FF: sd_wr for lba 0..3.
- During XFER of lba 2 (write), core writes addr 0x0400: next auto_tick rewrites lba 2 only.
- TIMEOUT=100, no sd_ack:
  - sd_wr drops after 100 cycles, err=1, busy=0
  - dirty bit re-set
  - next save clears err
- bk_ena=0 with load and save edges: no requests. reset=0 during XFER: sd_rd=0 and busy=0 the next cycle.

Source files
------------

// File: rtl/bk_sync_pkg.sv
// Shared types and constants for the backup-RAM sync engine.
package bk_sync_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, REQ, XFER} state_t;
  typedef enum logic {READ, WRITE} mode_t;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = $clog2(SECTOR_BYTES);
  localparam int CNT_W        = 22;

endpackage

// File: rtl/dirty_map.sv
// One bit per BSRAM sector, set by core writes and by a failed write-back,
// cleared per sector on write-back or all at once after a load; set wins.
module dirty_map
  import bk_sync_pkg::*;
#(
  parameter int SEC_W = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             set_en,
  input  logic [SEC_W-1:0] set_idx,
  input  logic             restore_en,
  input  logic [SEC_W-1:0] restore_idx,
  input  logic             clr_en,
  input  logic [SEC_W-1:0] clr_idx,
  input  logic             clr_all,
  input  logic [SEC_W-1:0] rd_idx,
  output logic             rd_bit
);

  localparam int NUM = 1 << SEC_W;

  logic [NUM-1:0] map_reg;
  logic [NUM-1:0] map_next;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_bit
    logic hit_set;
    logic hit_clr;
    assign hit_set = (set_en && set_idx == SEC_W'(gi)) ||
                     (restore_en && restore_idx == SEC_W'(gi));
    assign hit_clr = clr_all || (clr_en && clr_idx == SEC_W'(gi));
    assign map_next[gi] = hit_set ? 1'b1 : (hit_clr ? 1'b0 : map_reg[gi]);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset) map_reg <= '0;
    else        map_reg <= map_next;
  end

  assign rd_bit = map_reg[rd_idx];

endmodule

// File: rtl/bk_sync_ctrl.sv
// Sector-by-sector BSRAM <-> SD save-file transfer engine driving the
// hps_io sd_rd/sd_wr/sd_ack handshake, with dirty-sector autosave.
module bk_sync_ctrl
  import bk_sync_pkg::*;
#(
  parameter int SEC_W   = 8,
  parameter int TIMEOUT = 2000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic [23:0] ram_mask,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        auto_tick,
  input  logic        dl_done,
  input  logic        bsram_we,
  input  logic [16:0] bsram_addr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic        bk_loading,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg;
  mode_t            mode_reg;
  logic             all_reg;
  logic [SEC_W-1:0] idx_reg;
  logic [SEC_W-1:0] lba_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ack_prev_reg;
  logic             ack_seen_reg;
  logic             load_prev_reg;
  logic             save_prev_reg;
  logic             pend_reg;
  logic             rd_reg;
  logic             wr_reg;
  logic             loading_reg;
  logic             err_reg;

  logic [SEC_W-1:0] last_idx;
  logic [16-SECTOR_SHIFT:0] core_sec;
  logic             load_edge;
  logic             save_edge;
  logic             ack_rise;
  logic             dl_trig;
  logic             at_last;
  logic             timeout_hit;
  logic             sector_done;
  logic             dirty_bit;
  logic             unused_bits;

  assign last_idx    = ram_mask[SEC_W+SECTOR_SHIFT-1:SECTOR_SHIFT];
  assign core_sec    = bsram_addr[16:SECTOR_SHIFT];
  assign unused_bits = ^{ram_mask[23:SEC_W+SECTOR_SHIFT], ram_mask[SECTOR_SHIFT-1:0],
                         bsram_addr[SECTOR_SHIFT-1:0]};

  assign load_edge   = load_req & ~load_prev_reg;
  assign save_edge   = save_req & ~save_prev_reg;
  assign ack_rise    = sd_ack & ~ack_prev_reg;
  assign dl_trig     = dl_done | pend_reg;
  assign at_last     = (idx_reg == last_idx);
  // Timeout only counts while still waiting for the acknowledge to rise.
  assign timeout_hit = (state_reg == XFER) && !ack_seen_reg && !ack_rise &&
                       (cnt_reg >= CNT_LAST);
  assign sector_done = (state_reg == XFER) && ack_seen_reg && !sd_ack;

  dirty_map #(.SEC_W(SEC_W)) u_dirty (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .set_en      (bsram_we),
    .set_idx     (SEC_W'(core_sec)),
    .restore_en  (timeout_hit && mode_reg == WRITE),
    .restore_idx (idx_reg),
    .clr_en      (state_reg == REQ && mode_reg == WRITE),
    .clr_idx     (idx_reg),
    .clr_all     (sector_done && at_last && mode_reg == READ),
    .rd_idx      (idx_reg),
    .rd_bit      (dirty_bit)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mode_reg      <= READ;
      all_reg       <= 1'b0;
      idx_reg       <= '0;
      lba_reg       <= '0;
      cnt_reg       <= '0;
      ack_prev_reg  <= sd_ack;
      ack_seen_reg  <= 1'b0;
      load_prev_reg <= load_req;
      save_prev_reg <= save_req;
      pend_reg      <= 1'b0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      loading_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      load_prev_reg <= load_req;
      save_prev_reg <= save_req;
      ack_prev_reg  <= sd_ack;
      if (state_reg != IDLE && dl_done && bk_ena) pend_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          idx_reg      <= '0;
          ack_seen_reg <= 1'b0;
          if (!bk_ena) begin
            pend_reg <= 1'b0;
          end else if (dl_trig || load_edge) begin
            mode_reg    <= READ;
            loading_reg <= 1'b1;
            err_reg     <= 1'b0;
            pend_reg    <= 1'b0;
            state_reg   <= REQ;
          end else if (save_edge || auto_tick) begin
            mode_reg  <= WRITE;
            all_reg   <= save_edge;
            err_reg   <= 1'b0;
            state_reg <= SCAN;
          end
        end

        SCAN: begin
          if (!bk_ena)                   state_reg <= IDLE;
          else if (all_reg || dirty_bit) state_reg <= REQ;
          else if (at_last)              state_reg <= IDLE;
          else                           idx_reg   <= idx_reg + SEC_W'(1);
        end

        REQ: begin
          lba_reg      <= idx_reg;
          rd_reg       <= (mode_reg == READ);
          wr_reg       <= (mode_reg == WRITE);
          cnt_reg      <= '0;
          ack_seen_reg <= 1'b0;
          state_reg    <= XFER;
        end

        XFER: begin
          if (!ack_seen_reg) begin
            if (ack_rise) begin
              rd_reg       <= 1'b0;
              wr_reg       <= 1'b0;
              ack_seen_reg <= 1'b1;
            end else if (timeout_hit) begin
              rd_reg      <= 1'b0;
              wr_reg      <= 1'b0;
              err_reg     <= 1'b1;
              loading_reg <= 1'b0;
              state_reg   <= IDLE;
            end else if (cnt_reg != CNT_MAX) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else if (!sd_ack) begin
            ack_seen_reg <= 1'b0;
            // A dropped bk_ena ends the run only at a sector boundary.
            if (at_last || !bk_ena) begin
              loading_reg <= 1'b0;
              state_reg   <= IDLE;
            end else begin
              idx_reg   <= idx_reg + SEC_W'(1);
              state_reg <= (mode_reg == WRITE) ? SCAN : REQ;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sd_lba     = {{(32-SEC_W){1'b0}}, lba_reg};
  assign sd_rd      = rd_reg;
  assign sd_wr      = wr_reg;
  assign bk_loading = loading_reg;
  assign busy       = (state_reg != IDLE);
  assign err        = err_reg;

endmodule

// File: tb/tb_bk_sync_ctrl.sv
// Self-checking bench: an hps_io-style responder logs every sector handshake,
// and a sector-set model predicts which sectors each trigger must move.
module tb_bk_sync_ctrl;

  localparam int TO = 100;

  logic        clk_sys;
  logic        reset;
  logic        bk_ena;
  logic [23:0] ram_mask;
  logic        load_req;
  logic        save_req;
  logic        auto_tick;
  logic        dl_done;
  logic        bsram_we;
  logic [16:0] bsram_addr;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        bk_loading;
  logic        busy;
  logic        err;

  bk_sync_ctrl #(.SEC_W(8), .TIMEOUT(TO)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bk_ena     (bk_ena),
    .ram_mask   (ram_mask),
    .load_req   (load_req),
    .save_req   (save_req),
    .auto_tick  (auto_tick),
    .dl_done    (dl_done),
    .bsram_we   (bsram_we),
    .bsram_addr (bsram_addr),
    .sd_lba     (sd_lba),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .sd_ack     (sd_ack),
    .bk_loading (bk_loading),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    bit wr;
    bit loading;
    int lba;
  } xfer_t;

  xfer_t log_q[$];
  int    exp_lba[$];
  bit    exp_wr[$];
  bit    model_dirty[256];
  bit    ack_en;
  int    checks;
  int    fails;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // hps_io responder: acknowledges each request after a random delay.
  initial begin
    xfer_t e;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && (sd_rd || sd_wr)) begin
        e.wr = sd_wr;
        e.loading = bk_loading;
        e.lba = int'(sd_lba);
        log_q.push_back(e);
        $display("xfer %s lba=%0d loading=%0b", sd_wr ? "wr" : "rd", sd_lba, bk_loading);
        repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic core_write(input logic [16:0] a);
    @(negedge clk_sys);
    bsram_we = 1'b1;
    bsram_addr = a;
    model_dirty[a[16:9]] = 1'b1;
    @(negedge clk_sys);
    bsram_we = 1'b0;
  endtask

  task automatic pulse_auto();
    @(negedge clk_sys);
    auto_tick = 1'b1;
    @(negedge clk_sys);
    auto_tick = 1'b0;
  endtask

  task automatic pulse_dl();
    @(negedge clk_sys);
    dl_done = 1'b1;
    @(negedge clk_sys);
    dl_done = 1'b0;
  endtask

  task automatic wait_quiet(input int bound, output bit ok);
    int q = 0;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk_sys);
      q = busy ? 0 : q + 1;
      if (q >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected sector lists, derived from the trigger rules.
  task automatic model_auto(input int last);
    for (int s = 0; s <= last; s++)
      if (model_dirty[s]) begin
        exp_lba.push_back(s);
        exp_wr.push_back(1'b1);
        model_dirty[s] = 1'b0;
      end
  endtask

  task automatic model_save(input int last);
    for (int s = 0; s <= last; s++) begin
      exp_lba.push_back(s);
      exp_wr.push_back(1'b1);
      model_dirty[s] = 1'b0;
    end
  endtask

  task automatic model_read(input int last);
    for (int s = 0; s <= last; s++) begin
      exp_lba.push_back(s);
      exp_wr.push_back(1'b0);
    end
    foreach (model_dirty[i]) model_dirty[i] = 1'b0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    exp_lba.delete();
    exp_wr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bk_ena = 1'b1;
    ram_mask = 24'h1FFF;
    load_req = 1'b1;
    save_req = 1'b0;
    auto_tick = 1'b0;
    dl_done = 1'b0;
    bsram_we = 1'b0;
    bsram_addr = '0;
    ack_en = 1'b1;
    tick(3);
    checks++;
    if ({sd_rd, sd_wr, bk_loading, busy, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got rd/wr/load/busy/err=%b want 00000",
               {sd_rd, sd_wr, bk_loading, busy, err});
    end
    checks++;
    if (sd_lba !== 32'd0) begin
      fails++;
      $display("FAIL reset_lba: got %0d want 0", sd_lba);
    end
    reset = 1'b1;
    tick(6);
    checks++;
    if (busy !== 1'b0 || log_q.size() != 0) begin
      fails++;
      $display("FAIL reset_held_level: got busy=%b xfers=%0d want 0 and 0", busy, log_q.size());
    end
    load_req = 1'b0;
    tick(2);
  endtask

  task automatic test_dl_load();
    int bad = 0;
    int q = 0;
    bit done = 1'b0;
    ram_mask = 24'h1FFF;
    core_write(17'h0A00);
    clear_logs();
    model_read(15);
    pulse_dl();
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk_sys);
      if (busy !== bk_loading) bad++;
      q = busy ? 0 : q + 1;
      if (q >= 4) done = 1'b1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL dl_load_done: got busy after 3000 cycles want idle");
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL dl_load_loading: got %0d cycles bk_loading!=busy want 0", bad);
    end
    checks++;
    if (log_q.size() != exp_lba.size()) begin
      fails++;
      $display("FAIL dl_load_count: got %0d want %0d", log_q.size(), exp_lba.size());
    end
    foreach (exp_lba[i])
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i].lba != exp_lba[i] || log_q[i].wr != exp_wr[i] || log_q[i].loading != 1'b1) begin
          fails++;
          $display("FAIL dl_load_xfer%0d: got wr=%0b lba=%0d loading=%0b want wr=%0b lba=%0d loading=1",
                   i, log_q[i].wr, log_q[i].lba, log_q[i].loading, exp_wr[i], exp_lba[i]);
        end
      end
    checks++;
    if (bk_loading !== 1'b0) begin
      fails++;
      $display("FAIL dl_load_end: got bk_loading=%b want 0", bk_loading);
    end
    // The write before the load must have been discarded.
    clear_logs();
    model_auto(15);
    pulse_auto();
    wait_quiet(1000, done);
    checks++;
    if (!done || log_q.size() != exp_lba.size()) begin
      fails++;
      $display("FAIL dl_load_map_cleared: got %0d xfers done=%0b want %0d", log_q.size(), done, exp_lba.size());
    end
  endtask

  task automatic test_auto_pair();
    bit ok;
    ram_mask = 24'h1FFF;
    core_write(17'h0200);
    core_write(17'h1E00);
    clear_logs();
    model_auto(15);
    pulse_auto();
    wait_quiet(2000, ok);
    checks++;
    if (!ok || log_q.size() != exp_lba.size()) begin
      fails++;
      $display("FAIL auto_count: got %0d done=%0b want %0d", log_q.size(), ok, exp_lba.size());
    end
    foreach (exp_lba[i])
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i].lba != exp_lba[i] || log_q[i].wr != exp_wr[i]) begin
          fails++;
          $display("FAIL auto_xfer%0d: got wr=%0b lba=%0d want wr=%0b lba=%0d",
                   i, log_q[i].wr, log_q[i].lba, exp_wr[i], exp_lba[i]);
        end
      end
    clear_logs();
    pulse_auto();
    wait_quiet(1000, ok);
    checks++;
    if (!ok || log_q.size() != 0) begin
      fails++;
      $display("FAIL auto_map_empty: got %0d xfers done=%0b want 0", log_q.size(), ok);
    end
  endtask

  task automatic test_save_during_xfer();
    bit ok;
    bit seen = 1'b0;
    ram_mask = 24'h07FF;
    clear_logs();
    model_save(3);
    @(negedge clk_sys);
    save_req = 1'b1;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk_sys);
      if (sd_wr && sd_lba == 32'd2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL save_lba2_seen: got no sd_wr for lba 2 want one");
    end
    core_write(17'h0400);
    wait_quiet(2000, ok);
    save_req = 1'b0;
    checks++;
    if (!ok || log_q.size() != exp_lba.size()) begin
      fails++;
      $display("FAIL save_count: got %0d done=%0b want %0d", log_q.size(), ok, exp_lba.size());
    end
    foreach (exp_lba[i])
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i].lba != exp_lba[i] || log_q[i].wr != exp_wr[i]) begin
          fails++;
          $display("FAIL save_xfer%0d: got wr=%0b lba=%0d want wr=%0b lba=%0d",
                   i, log_q[i].wr, log_q[i].lba, exp_wr[i], exp_lba[i]);
        end
      end
    clear_logs();
    model_auto(3);
    pulse_auto();
    wait_quiet(1000, ok);
    checks++;
    if (!ok || log_q.size() != 1 || exp_lba.size() != 1) begin
      fails++;
      $display("FAIL redirty_count: got %0d done=%0b want 1", log_q.size(), ok);
    end else if (log_q[0].lba != exp_lba[0] || log_q[0].wr != 1'b1) begin
      fails++;
      $display("FAIL redirty_lba: got wr=%0b lba=%0d want wr=1 lba=%0d", log_q[0].wr, log_q[0].lba, exp_lba[0]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen = 1'b0;
    int high = 0;
    ack_en = 1'b0;
    ram_mask = 24'h07FF;
    core_write(17'h0200);
    pulse_auto();
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_sys);
      if (sd_wr) seen = 1'b1;
    end
    while (seen && sd_wr && high < 1000) begin
      high++;
      @(negedge clk_sys);
    end
    checks++;
    if (high != TO) begin
      fails++;
      $display("FAIL timeout_len: got sd_wr high %0d cycles want %0d", high, TO);
    end
    tick(1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_flags: got err=%b busy=%b want err=1 busy=0", err, busy);
    end
    ack_en = 1'b1;
    clear_logs();
    model_auto(3);
    pulse_auto();
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_clear: got err=%b want 0", err);
    end
    wait_quiet(1000, ok);
    checks++;
    if (!ok || log_q.size() != 1 || exp_lba.size() != 1) begin
      fails++;
      $display("FAIL timeout_redirty: got %0d xfers done=%0b want 1", log_q.size(), ok);
    end else if (log_q[0].lba != exp_lba[0] || log_q[0].wr != 1'b1) begin
      fails++;
      $display("FAIL timeout_redirty_lba: got lba=%0d want %0d", log_q[0].lba, exp_lba[0]);
    end
  endtask

  task automatic test_bk_ena_off();
    int busy_cnt = 0;
    clear_logs();
    bk_ena = 1'b0;
    @(negedge clk_sys);
    load_req = 1'b1;
    save_req = 1'b1;
    auto_tick = 1'b1;
    dl_done = 1'b1;
    @(negedge clk_sys);
    auto_tick = 1'b0;
    dl_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_sys);
      if (busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 0 || log_q.size() != 0) begin
      fails++;
      $display("FAIL bk_ena_off: got busy cycles=%0d xfers=%0d want 0 and 0", busy_cnt, log_q.size());
    end
    load_req = 1'b0;
    save_req = 1'b0;
    tick(2);
    bk_ena = 1'b1;
    tick(2);
  endtask

  task automatic test_priority_pending();
    bit ok;
    bit seen = 1'b0;
    ram_mask = 24'h07FF;
    clear_logs();
    model_read(3);
    @(negedge clk_sys);
    dl_done = 1'b1;
    save_req = 1'b1;
    auto_tick = 1'b1;
    @(negedge clk_sys);
    dl_done = 1'b0;
    auto_tick = 1'b0;
    wait_quiet(2000, ok);
    save_req = 1'b0;
    checks++;
    if (!ok || log_q.size() != exp_lba.size()) begin
      fails++;
      $display("FAIL prio_count: got %0d done=%0b want %0d", log_q.size(), ok, exp_lba.size());
    end
    foreach (exp_lba[i])
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i].lba != exp_lba[i] || log_q[i].wr != exp_wr[i]) begin
          fails++;
          $display("FAIL prio_xfer%0d: got wr=%0b lba=%0d want wr=%0b lba=%0d",
                   i, log_q[i].wr, log_q[i].lba, exp_wr[i], exp_lba[i]);
        end
      end
    // dl_done during a save is held and run once the save finishes.
    clear_logs();
    model_save(3);
    model_read(3);
    @(negedge clk_sys);
    save_req = 1'b1;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_sys);
      if (sd_wr) seen = 1'b1;
    end
    pulse_dl();
    wait_quiet(3000, ok);
    save_req = 1'b0;
    checks++;
    if (!seen || !ok || log_q.size() != exp_lba.size()) begin
      fails++;
      $display("FAIL pend_count: got %0d done=%0b want %0d", log_q.size(), ok, exp_lba.size());
    end
    foreach (exp_lba[i])
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i].lba != exp_lba[i] || log_q[i].wr != exp_wr[i]) begin
          fails++;
          $display("FAIL pend_xfer%0d: got wr=%0b lba=%0d want wr=%0b lba=%0d",
                   i, log_q[i].wr, log_q[i].lba, exp_wr[i], exp_lba[i]);
        end
      end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      int last = $urandom_range(1, 20);
      int nw = $urandom_range(0, 6);
      int kind = $urandom_range(0, 2);
      ram_mask = 24'((last + 1) * 512 - 1);
      for (int w = 0; w < nw; w++)
        core_write({8'($urandom_range(0, 24)), 9'($urandom_range(0, 511))});
      clear_logs();
      @(negedge clk_sys);
      case (kind)
        0: begin model_auto(last); auto_tick = 1'b1; end
        1: begin model_save(last); save_req = 1'b1; end
        default: begin model_read(last); load_req = 1'b1; end
      endcase
      @(negedge clk_sys);
      auto_tick = 1'b0;
      wait_quiet(4000, ok);
      save_req = 1'b0;
      load_req = 1'b0;
      checks++;
      if (!ok || log_q.size() != exp_lba.size()) begin
        fails++;
        $display("FAIL rand%0d_count: kind=%0d got %0d done=%0b want %0d",
                 it, kind, log_q.size(), ok, exp_lba.size());
      end
      foreach (exp_lba[i])
        if (i < log_q.size()) begin
          checks++;
          if (log_q[i].lba != exp_lba[i] || log_q[i].wr != exp_wr[i]) begin
            fails++;
            $display("FAIL rand%0d_xfer%0d: got wr=%0b lba=%0d want wr=%0b lba=%0d",
                     it, i, log_q[i].wr, log_q[i].lba, exp_wr[i], exp_lba[i]);
          end
        end
      tick(2);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    ack_en = 1'b0;
    ram_mask = 24'h1FFF;
    pulse_dl();
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk_sys);
      if (sd_rd) seen = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (!seen || sd_rd !== 1'b0 || busy !== 1'b0 || bk_loading !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: seen=%0b got rd=%b busy=%b loading=%b want 0 0 0",
               seen, sd_rd, busy, bk_loading);
    end
    foreach (model_dirty[i]) model_dirty[i] = 1'b0;
    reset = 1'b1;
    tick(2);
    ack_en = 1'b1;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    foreach (model_dirty[i]) model_dirty[i] = 1'b0;
    test_reset();
    test_dl_load();
    test_auto_pair();
    test_save_during_xfer();
    test_timeout();
    test_bk_ena_off();
    test_priority_pending();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
